// File: rtl/sample_feeder.sv
// sample_feeder: buffers strobed 16-bit samples in a small FIFO and offers them
// to a downstream consumer over a Rdy/Ack handshake, flagging overflow and Ack timeout.
module sample_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              SampleIn,
    input  logic                     SampleVld,
    output logic [15:0]              DataOut,
    output logic                     Rdy,
    input  logic                     Ack,
    output logic [$clog2(DEPTH):0]   Level,
    input  logic                     ClrErr,
    output logic                     Overflow,
    output logic                     AckTimeout
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int          LW     = AW + 1;
    localparam logic [15:0] TMO    = 16'(TIMEOUT);
    localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic [15:0]   r_tcnt;
    logic          r_ovf;
    logic          r_tmo;

    logic          w_rdy;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_tmo_set;
    logic [LW-1:0] w_count_nxt;
    logic [15:0]   w_tcnt_nxt;

    assign w_rdy     = (r_count != '0);
    assign w_full    = (r_count == LW'(DEPTH));
    assign w_pop     = Ack && w_rdy;
    // A pop on the same edge frees the head slot, so a full FIFO can still accept.
    assign w_push    = SampleVld && (!w_full || w_pop);
    assign w_drop    = SampleVld && w_full && !w_pop;
    // Only the transition into TIMEOUT sets the flag, so ClrErr works while saturated.
    assign w_tmo_set = w_rdy && !Ack && (r_tcnt == TMO_M1);

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + LW'(1);
            2'b01:   w_count_nxt = r_count - LW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Missing-Ack counter next-state, saturating at TIMEOUT.
    always_comb begin
        w_tcnt_nxt = r_tcnt;
        if (!w_rdy || Ack) begin
            w_tcnt_nxt = 16'h0000;
        end else if (r_tcnt != TMO) begin
            w_tcnt_nxt = r_tcnt + 16'h0001;
        end else begin
            w_tcnt_nxt = r_tcnt;
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= SampleIn;
        end
    end

    // Pointers, occupancy, timeout counter and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tcnt   <= 16'h0000;
            r_ovf    <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_ovf   <= w_drop    || (r_ovf && !ClrErr);
            r_tmo   <= w_tmo_set || (r_tmo && !ClrErr);
        end
    end

    assign Rdy        = w_rdy;
    assign DataOut    = w_rdy ? r_mem[r_rd_ptr] : 16'h0000;
    assign Level      = r_count;
    assign Overflow   = r_ovf;
    assign AckTimeout = r_tmo;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed self-checking bench for sample_feeder (DEPTH=8, TIMEOUT=4).
module tb_sample_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] SampleIn;
    logic        SampleVld;
    logic [15:0] DataOut;
    logic        Rdy;
    logic        Ack;
    logic [3:0]  Level;
    logic        ClrErr;
    logic        Overflow;
    logic        AckTimeout;

    int checks = 0;
    int errors = 0;

    sample_feeder #(.DEPTH(8), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .SampleIn   (SampleIn),
        .SampleVld  (SampleVld),
        .DataOut    (DataOut),
        .Rdy        (Rdy),
        .Ack        (Ack),
        .Level      (Level),
        .ClrErr     (ClrErr),
        .Overflow   (Overflow),
        .AckTimeout (AckTimeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        Ack = 1'b1;
        step();
        Ack = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        SampleIn  = v;
        SampleVld = 1'b1;
        step();
        SampleVld = 1'b0;
    endtask

    logic [15:0] rx[$];
    logic [15:0] e;
    bit          cap;

    initial begin
        reset = 1'b1; SampleIn = 16'h0000; SampleVld = 1'b0; Ack = 1'b0; ClrErr = 1'b0;
        step(); step();
        check_val("rst_rdy",   32'(Rdy),        32'd0);
        check_val("rst_data",  32'(DataOut),    32'd0);
        check_val("rst_level", 32'(Level),      32'd0);
        check_val("rst_ovf",   32'(Overflow),   32'd0);
        check_val("rst_tmo",   32'(AckTimeout), 32'd0);
        reset = 1'b0;
        step();

        // single word offer and accept
        push(16'h1234);
        check_val("one_rdy",   32'(Rdy),     32'd1);
        check_val("one_data",  32'(DataOut), 32'h1234);
        check_val("one_level", 32'(Level),   32'd1);
        ack_pulse();
        check_val("one_rdy0",  32'(Rdy),     32'd0);
        check_val("one_data0", 32'(DataOut), 32'd0);
        check_val("one_lvl0",  32'(Level),   32'd0);

        // back-to-back pushes drained by a consumer model, one word per 2 cycles
        cap = 1'b0;
        for (int c = 0; c < 40; c++) begin
            SampleVld = (c < 8);
            SampleIn  = 16'(c * 100);
            if (Ack) begin
                Ack = 1'b0;
            end else if (cap) begin
                Ack = 1'b1;
                cap = 1'b0;
            end
            if (!Ack && !cap && Rdy) begin
                rx.push_back(DataOut);
                cap = 1'b1;
            end
            step();
        end
        SampleVld = 1'b0;
        Ack = 1'b0;
        check_val("flow_count", 32'(rx.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            e = (i < rx.size()) ? rx[i] : 16'hFFFF;
            check_val($sformatf("flow_word%0d", i), 32'(e), 32'(i * 100));
        end
        check_val("flow_ovf",   32'(Overflow), 32'd0);
        check_val("flow_level", 32'(Level),    32'd0);

        // overflow: 9 pushes into an 8-deep FIFO with no Ack
        for (int i = 0; i < 9; i++) push(16'hA000 + 16'(i));
        check_val("ovf_level", 32'(Level),    32'd8);
        check_val("ovf_flag",  32'(Overflow), 32'd1);
        check_val("ovf_head",  32'(DataOut),  32'hA000);
        SampleIn = 16'hBEEF; SampleVld = 1'b1; Ack = 1'b1;
        step();
        SampleVld = 1'b0; Ack = 1'b0;
        check_val("full_pp_level", 32'(Level),   32'd8);
        check_val("full_pp_head",  32'(DataOut), 32'hA001);
        for (int i = 0; i < 8; i++) begin
            e = (i < 7) ? 16'hA001 + 16'(i) : 16'hBEEF;
            check_val($sformatf("drain%0d", i), 32'(DataOut), 32'(e));
            ack_pulse();
        end
        check_val("drain_level", 32'(Level), 32'd0);
        ClrErr = 1'b1; step(); ClrErr = 1'b0;
        check_val("clr_ovf", 32'(Overflow),   32'd0);
        check_val("clr_tmo", 32'(AckTimeout), 32'd0);

        // Ack timeout after the 4th Rdy cycle
        push(16'h5555);
        step(); step(); step();
        check_val("tmo_before", 32'(AckTimeout), 32'd0);
        step();
        check_val("tmo_set", 32'(AckTimeout), 32'd1);
        ClrErr = 1'b1; step(); ClrErr = 1'b0;
        check_val("tmo_clr",  32'(AckTimeout), 32'd0);
        check_val("tmo_held", 32'(DataOut),    32'h5555);
        ack_pulse();
        check_val("tmo_pop",  32'(Level),      32'd0);

        // spurious Ack while empty
        ack_pulse();
        check_val("spur_level", 32'(Level), 32'd0);
        check_val("spur_rdy",   32'(Rdy),   32'd0);
        push(16'h0007);
        push(16'h0008);
        check_val("spur_h1", 32'(DataOut), 32'h0007);
        ack_pulse();
        check_val("spur_h2", 32'(DataOut), 32'h0008);
        ack_pulse();
        check_val("spur_end", 32'(Level), 32'd0);

        // reset mid-transfer with 5 words buffered and a timeout pending
        for (int i = 0; i < 5; i++) push(16'hC000 + 16'(i));
        check_val("mid_level", 32'(Level),      32'd5);
        check_val("mid_tmo",   32'(AckTimeout), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mrst_rdy",   32'(Rdy),        32'd0);
        check_val("mrst_data",  32'(DataOut),    32'd0);
        check_val("mrst_level", 32'(Level),      32'd0);
        check_val("mrst_tmo",   32'(AckTimeout), 32'd0);
        Ack = 1'b1;
        step();
        reset = 1'b0;
        step();
        Ack = 1'b0;
        check_val("post_ack_level", 32'(Level), 32'd0);
        push(16'h1234);
        check_val("post_level", 32'(Level),   32'd1);
        check_val("post_data",  32'(DataOut), 32'h1234);
        ack_pulse();
        check_val("post_empty", 32'(Level),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
